if_stage_pipe: RTL and testbench
================================

Name: if_stage_pipe

Overview:
- Fetch stage plus IF/ID pipeline register, directly upstream of hazard detection.
- Holds the PC and drives the instruction-memory address. Latches the fetched instruction and PC+4 into the IF/ID register.
- Honours the Stall_PC / Stall_ID outputs of hazard detection, and applies branch/jump redirects resolved in ID.
- Keeps saturating stall and flush event counters for pipeline performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word written into IF/ID on flush or bubble.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous reset, active-high
- Stall_PC  in  1  from hazard detection; hold PC
- Stall_ID  in  1  from hazard detection; hold IF/ID register
- Branch_Taken  in  1  branch resolved taken in ID this cycle
- Branch_Target  in  32  branch destination
- Jump  in  1  jump (j/jal/jr) in ID this cycle
- Jump_Target  in  32  jump destination
- IF_Instruction  in  32  combinational read data from instruction memory at IF_PC
- IF_PC  out  32  current PC, instruction-memory address
- ID_Instruction  out  32  IF/ID instruction
- ID_PCPlus4  out  32  IF/ID PC+4
- ID_Valid  out  1  IF/ID holds a real instruction (0 = bubble)
- Stall_Count  out  CNT_W  cycles with Stall_PC=1
- Flush_Count  out  CNT_W  redirects accepted

Behaviour:
Reset (async, Rst=1, immediate and independent of Clk):
- IF_PC = RESET_PC, ID_Instruction = NOP_INSTR, ID_PCPlus4 = 0, ID_Valid = 0.
- Both counters = 0.
- Reset mid-operation discards all in-flight state. First fetch after release is at RESET_PC.

Redirect definition:
- redirect = (Jump | Branch_Taken) & ~Stall_PC.
- Target = Jump_Target if Jump=1 (jump wins over simultaneous branch), else Branch_Target.
- Target bits [1:0] are forced to 2'b00.

Next PC, per rising edge, in priority order:
1. Stall_PC=1: PC holds. Any redirect is ignored; the stalled branch/jump stays in ID and is re-presented next cycle.
2. redirect: PC <= target.
3. Otherwise: PC <= PC + 4, 32-bit wrap (32'hFFFF_FFFC + 4 -> 0).

IF/ID register, per rising edge, in priority order:
1. Stall_ID=1: hold all three fields.
2. redirect=1: flush. ID_Instruction <= NOP_INSTR, ID_Valid <= 0, ID_PCPlus4 <= PC+4 (debug only).
3. Stall_PC=1 and Stall_ID=0: insert bubble, same values as flush.
4. Otherwise: ID_Instruction <= IF_Instruction, ID_PCPlus4 <= IF_PC + 4, ID_Valid <= 1.

Timing:
- Latency: instruction at IF_PC appears on ID_Instruction one cycle later.
- Taken branch costs exactly one bubble.

Counters:
- Stall_Count increments on each edge with Stall_PC=1.
- Flush_Count increments on each edge with redirect=1.
- Both saturate at all-ones and never wrap.

Combinational path:
- IF_PC is a register output; no combinational path from any input to IF_PC.
- IF_Instruction is sampled only at the clock edge.

Test Plan:
- Reset release, no stalls, memory returns 0x20080001, 0x20090002, ... -> IF_PC sequence 0, 4, 8, 12. ID_Instruction lags one cycle. ID_Valid=1 from cycle 2. ID_PCPlus4 = 4, 8, 12.
- Stall_PC=Stall_ID=1 for 2 cycles at IF_PC=0x10 -> IF_PC stays 0x10 and IF/ID unchanged for 2 edges, then resumes at 0x14. Stall_Count=2.
- Branch_Taken=1, Branch_Target=0x40 at IF_PC=0x0C -> next IF_PC=0x40. IF/ID = NOP_INSTR with ID_Valid=0 for one cycle. Flush_Count=1.
- Jump=1, Jump_Target=0x83 together with Branch_Taken=1, Branch_Target=0x40 -> IF_PC=0x80. Single flush. Flush_Count=1.
- Branch_Taken=1 with Stall_PC=Stall_ID=1 -> redirect ignored, PC holds, Flush_Count unchanged. Next cycle with stall released -> redirect taken.
- Rst pulsed asynchronously mid-cycle while IF_PC=0x2C -> outputs reset immediately without a clock edge. Stall_Count held at all-ones for 3 extra stall cycles stays all-ones (separate run, CNT_W=4 -> 4'hF).

Source files
------------

// File: rtl/if_stage_pipe.sv
// if_stage_pipe: fetch PC and IF/ID pipeline register with stall/redirect handling
// and saturating stall/flush event counters.
module if_stage_pipe #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall_PC,
    input  logic             Stall_ID,
    input  logic             Branch_Taken,
    input  logic [31:0]      Branch_Target,
    input  logic             Jump,
    input  logic [31:0]      Jump_Target,
    input  logic [31:0]      IF_Instruction,
    output logic [31:0]      IF_PC,
    output logic [31:0]      ID_Instruction,
    output logic [31:0]      ID_PCPlus4,
    output logic             ID_Valid,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);
    logic             w_redirect;
    logic             w_bubble;
    logic [31:0]      w_target_raw;
    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic [31:0]      r_pc4;
    logic             r_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // a stalled branch/jump stays in ID and is re-presented, so it cannot redirect yet
    assign w_redirect   = (Jump | Branch_Taken) & ~Stall_PC;
    assign w_bubble     = w_redirect | Stall_PC;
    assign w_target_raw = Jump ? Jump_Target : Branch_Target;
    assign w_target     = {w_target_raw[31:2], 2'b00};
    assign w_pc_plus4   = r_pc + 32'd4;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_pc <= RESET_PC;
        else if (!Stall_PC)
            r_pc <= w_redirect ? w_target : w_pc_plus4;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (!Stall_ID) begin
            r_instr <= w_bubble ? NOP_INSTR : IF_Instruction;
            r_pc4   <= w_pc_plus4;
            r_valid <= ~w_bubble;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (Stall_PC && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_redirect && !(&r_flush_cnt))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign IF_PC          = r_pc;
    assign ID_Instruction = r_instr;
    assign ID_PCPlus4     = r_pc4;
    assign ID_Valid       = r_valid;
    assign Stall_Count    = r_stall_cnt;
    assign Flush_Count    = r_flush_cnt;
endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: directed vectors, expected responses queued and checked by a monitor
module tb_if_stage_pipe;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall_PC, Stall_ID, Branch_Taken, Jump;
    logic [31:0] Branch_Target, Jump_Target, IF_Instruction;
    logic [31:0] IF_PC, ID_Instruction, ID_PCPlus4;
    logic        ID_Valid;
    logic [15:0] Stall_Count, Flush_Count;
    logic [31:0] IF_PC4, ID_Instruction4, ID_PCPlus44;
    logic        ID_Valid4;
    logic [3:0]  Stall_Count4, Flush_Count4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        int          sc;
        int          fc;
    } exp_t;
    exp_t q[$];

    always #5 Clk = ~Clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return 32'h2008_0001 + (a >> 2) * 32'h0001_0001;
    endfunction

    assign IF_Instruction = imem(IF_PC);

    if_stage_pipe dut (
        .Clk(Clk), .Rst(Rst), .Stall_PC(Stall_PC), .Stall_ID(Stall_ID),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .Jump(Jump), .Jump_Target(Jump_Target), .IF_Instruction(IF_Instruction),
        .IF_PC(IF_PC), .ID_Instruction(ID_Instruction), .ID_PCPlus4(ID_PCPlus4),
        .ID_Valid(ID_Valid), .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    if_stage_pipe #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Rst(Rst), .Stall_PC(Stall_PC), .Stall_ID(Stall_ID),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .Jump(Jump), .Jump_Target(Jump_Target), .IF_Instruction(IF_Instruction),
        .IF_PC(IF_PC4), .ID_Instruction(ID_Instruction4), .ID_PCPlus4(ID_PCPlus44),
        .ID_Valid(ID_Valid4), .Stall_Count(Stall_Count4), .Flush_Count(Flush_Count4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        int s4, f4;
        s4 = e.sc > 15 ? 15 : e.sc;
        f4 = e.fc > 15 ? 15 : e.fc;
        chk("IF_PC", IF_PC, e.pc);
        chk("ID_Instruction", ID_Instruction, e.instr);
        chk("ID_PCPlus4", ID_PCPlus4, e.pc4);
        chk("ID_Valid", {31'd0, ID_Valid}, {31'd0, e.valid});
        chk("Stall_Count", {16'd0, Stall_Count}, e.sc);
        chk("Flush_Count", {16'd0, Flush_Count}, e.fc);
        chk("Stall_Count4", {28'd0, Stall_Count4}, s4);
        chk("Flush_Count4", {28'd0, Flush_Count4}, f4);
    endtask

    always @(posedge Clk) begin
        #1;
        if (q.size() > 0)
            chk_all(q.pop_front());
    end

    // called at a negedge: drive one cycle of inputs, queue the state expected after the next edge
    task automatic step(input logic sp, input logic sid, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic [31:0] e_pc,
                        input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_v,
                        input int e_sc, input int e_fc);
        Stall_PC = sp; Stall_ID = sid; Branch_Taken = br; Branch_Target = bt;
        Jump = j; Jump_Target = jt;
        q.push_back('{e_pc, e_instr, e_pc4, e_v, e_sc, e_fc});
        @(negedge Clk);
    endtask

    task automatic run(input logic [31:0] e_pc, input logic [31:0] e_ipc, input int e_sc,
                       input int e_fc);
        step(0, 0, 0, 0, 0, 0, e_pc, imem(e_ipc), e_ipc + 32'd4, 1'b1, e_sc, e_fc);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1; Stall_PC = 0; Stall_ID = 0; Branch_Taken = 0; Jump = 0;
        Branch_Target = 0; Jump_Target = 0;
        #1;
        chk_all('{32'h0, 32'h0, 32'h0, 1'b0, 0, 0});
        @(negedge Clk);
        Rst = 1'b0;
        run(32'h04, 32'h00, 0, 0);
        run(32'h08, 32'h04, 0, 0);
        run(32'h0C, 32'h08, 0, 0);
        step(0, 0, 1, 32'h40, 0, 0, 32'h40, 32'h0, 32'h10, 0, 0, 1);
        run(32'h44, 32'h40, 0, 1);
        step(1, 1, 0, 0, 0, 0, 32'h44, imem(32'h40), 32'h44, 1, 1, 1);
        step(1, 1, 0, 0, 0, 0, 32'h44, imem(32'h40), 32'h44, 1, 2, 1);
        run(32'h48, 32'h44, 2, 1);
        step(1, 0, 0, 0, 0, 0, 32'h48, 32'h0, 32'h4C, 0, 3, 1);
        run(32'h4C, 32'h48, 3, 1);
        step(0, 0, 1, 32'h40, 1, 32'h83, 32'h80, 32'h0, 32'h50, 0, 3, 2);
        step(1, 1, 1, 32'h100, 0, 0, 32'h80, 32'h0, 32'h50, 0, 4, 2);
        step(0, 0, 1, 32'h100, 0, 0, 32'h100, 32'h0, 32'h84, 0, 4, 3);
        run(32'h104, 32'h100, 4, 3);
        step(0, 1, 0, 0, 0, 0, 32'h108, imem(32'h100), 32'h104, 1, 4, 3);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0, 32'h10C, 0, 4, 4);
        run(32'h0, 32'hFFFF_FFFC, 4, 4);
        run(32'h4, 32'h0, 4, 4);
        for (int i = 2; i <= 11; i++)
            run(32'(4 * i), 32'(4 * (i - 1)), 4, 4);
        chk("pre_reset_pc", IF_PC, 32'h2C);
        #2 Rst = 1'b1;
        #1;
        chk_all('{32'h0, 32'h0, 32'h0, 1'b0, 0, 0});
        #1 Rst = 1'b0;
        for (int i = 1; i <= 18; i++)
            step(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, i, 0);
        @(negedge Clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
